pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//
// Program counter for a simple in-order pipeline. Holds the current fetch
// address, offers the sequential successor combinationally, and remembers a
// branch that resolves while the front end is stalled so the redirect is not
// lost once the stall lifts.
//
// Parameters
//   RESET_VECTOR : address loaded into PC while reset is asserted
//   PC_STEP      : byte increment for sequential fetch
//
// Ports
//   PC         (out, 32) : current program counter, straight from a register
//   PC_4       (out, 32) : PC + PC_STEP, modulo 2^32
//   BRANCH_PC  (in,  32) : branch / jump target address, used unmodified
//   CLK        (in)      : single clock, all state changes on the rising edge
//   RESET      (in)      : asynchronous, active-low reset
//   CON_BRANCH (in)      : branch taken this cycle
//   BUSY_WAIT  (in)      : stall request, active high; PC holds while set
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  output logic [31:0] PC,
  output logic [31:0] PC_4,
  input  logic [31:0] BRANCH_PC,
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CON_BRANCH,
  input  logic        BUSY_WAIT
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        pend_valid_next;
  logic [31:0] pend_target_next;

  // Sequential successor; the 32-bit add drops the carry so the address
  // space wraps naturally from 0xFFFF_FFFC back to 0.
  assign PC_4 = pc_reg + STEP;
  assign PC   = pc_reg;

  // Next-PC selection. A stall freezes the PC; otherwise a branch presented
  // this cycle wins over one remembered from an earlier stall, which in turn
  // wins over plain sequential fetch.
  always_comb begin
    next_pc = PC_4;
    if (BUSY_WAIT) begin
      next_pc = pc_reg;
    end else if (CON_BRANCH) begin
      next_pc = BRANCH_PC;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end
  end

  // Pending-branch bookkeeping. Branches arriving during a stall are
  // captured (the newest one overwrites any older capture); the entry is
  // consumed on the first non-stalled edge, whether it is used or
  // superseded by a fresh branch on that same edge.
  always_comb begin
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    if (BUSY_WAIT) begin
      if (CON_BRANCH) begin
        pend_valid_next  = 1'b1;
        pend_target_next = BRANCH_PC;
      end
    end else begin
      pend_valid_next = 1'b0;
    end
  end

  // PC register; reset forces the vector asynchronously.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= next_pc;
    end
  end

  // Pending-branch register; reset discards any captured branch so it can
  // never be taken after reset releases.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pend_valid  <= 1'b0;
      pend_target <= 32'h0000_0000;
    end else begin
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic [31:0] PC;
  logic [31:0] PC_4;
  logic [31:0] BRANCH_PC;
  logic        CLK;
  logic        RESET;
  logic        CON_BRANCH;
  logic        BUSY_WAIT;

  int total;
  int bad;

  // Reference model state: architectural PC plus the remembered branch.
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_pt;

  pc_unit dut (
    .PC(PC),
    .PC_4(PC_4),
    .BRANCH_PC(BRANCH_PC),
    .CLK(CLK),
    .RESET(RESET),
    .CON_BRANCH(CON_BRANCH),
    .BUSY_WAIT(BUSY_WAIT)
  );

  // 10 ns clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural view of one rising edge, straight from the priority rules.
  task automatic modelEdge(input logic busy, input logic br, input logic [31:0] tgt);
    if (busy) begin
      if (br) begin
        m_pv = 1'b1;
        m_pt = tgt;
      end
    end else if (br) begin
      m_pc = tgt;
      m_pv = 1'b0;
    end else if (m_pv) begin
      m_pc = m_pt;
      m_pv = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic modelReset();
    m_pc = 32'h0;
    m_pv = 1'b0;
    m_pt = 32'h0;
  endtask

  // Drive inputs, take one edge, then compare PC and PC_4 just after it.
  task automatic applyStimulus(input logic busy, input logic br, input logic [31:0] tgt);
    BUSY_WAIT  = busy;
    CON_BRANCH = br;
    BRANCH_PC  = tgt;
    @(posedge CLK);
    modelEdge(busy, br, tgt);
    #1;
    checkOutput("pc", PC, m_pc);
    checkOutput("pc_4", PC_4, m_pc + 32'd4);
  endtask

  // Assert reset between edges, check the asynchronous effect, and release
  // it near a falling edge with quiet inputs.
  task automatic asyncReset(input int delay_ns);
    #(delay_ns);
    RESET = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_pc", PC, 32'h0);
    checkOutput("rst_pc_4", PC_4, 32'h4);
    @(negedge CLK);
    BUSY_WAIT  = 1'b0;
    CON_BRANCH = 1'b0;
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    modelReset();

    // Reset with unknown inputs, which must not leak past release.
    RESET      = 1'b0;
    BUSY_WAIT  = 1'bx;
    CON_BRANCH = 1'bx;
    BRANCH_PC  = 32'hxxxx_xxxx;
    #3;
    checkOutput("por_pc", PC, 32'h0);
    checkOutput("por_pc_4", PC_4, 32'h4);
    @(posedge CLK);
    #1;
    checkOutput("por_hold_pc", PC, 32'h0);
    @(negedge CLK);
    BUSY_WAIT  = 1'b0;
    CON_BRANCH = 1'b0;
    BRANCH_PC  = 32'h0;
    #1;
    RESET = 1'b1;
    #1;
    checkOutput("release_pc", PC, 32'h0);

    // Sequential run 4, 8, 12, 16, 20
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("seq_const", PC, 32'(i * 4));
    end

    // Stall at 20 for two edges, then resume to 24
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stall1", PC, 32'd20);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stall2", PC, 32'd20);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("unstall", PC, 32'd24);

    // Direct branch to 100, then sequential 104
    applyStimulus(1'b0, 1'b1, 32'd100);
    checkOutput("br_pc", PC, 32'd100);
    checkOutput("br_pc_4", PC_4, 32'd104);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("br_next", PC, 32'd104);

    // Branch captured during stall, taken on first free edge
    applyStimulus(1'b1, 1'b1, 32'h200);
    checkOutput("pend_hold1", PC, 32'd104);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("pend_hold2", PC, 32'd104);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pend_take", PC, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pend_after", PC, 32'h204);

    // Later capture in the same stall overwrites the earlier one
    applyStimulus(1'b1, 1'b1, 32'h300);
    applyStimulus(1'b1, 1'b1, 32'h400);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pend_overwrite", PC, 32'h400);

    // Direct branch on release beats the pending one
    applyStimulus(1'b1, 1'b1, 32'h500);
    applyStimulus(1'b0, 1'b1, 32'h600);
    checkOutput("direct_over_pend", PC, 32'h600);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pend_dropped", PC, 32'h604);

    // Wrap-around
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_4", PC_4, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc", PC, 32'h0);

    // Async reset mid-cycle with a branch pending
    applyStimulus(1'b1, 1'b1, 32'h0000_0700);
    asyncReset(2);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post_rst1", PC, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("post_rst2", PC, 32'd8);

    // Randomized run against the model, with occasional async resets
    for (int n = 0; n < 600; n++) begin
      logic        busy;
      logic        br;
      logic [31:0] tgt;
      busy = ($urandom_range(0, 99) < 35);
      br   = ($urandom_range(0, 99) < 25);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = {$urandom_range(0, 255), 2'b00} & 32'h0000_03FC;
        default: tgt = $urandom;
      endcase
      if ($urandom_range(0, 59) == 0) begin
        asyncReset(int'($urandom_range(1, 3)));
      end
      applyStimulus(busy, br, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
